conv_loop_ctrl: RTL and testbench

CONV_LOOP_CTRL -- requirements
Module: conv_loop_ctrl

---
 rtl/conv_loop_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_conv_loop_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_loop_ctrl.sv
// conv_loop_ctrl: layer loop sequencer (LOAD_K -> LOAD_I -> MAC per channel group, then OUTPUT per result).
// Define CONV_LOOP_CTRL_OUT_HANDSHAKE_EN to add the output_ready handshake on the result serializer.
module conv_loop_ctrl #(
  parameter  int FEATURE_MAP_WIDTH  = 1024,
  parameter  int FEATURE_MAP_HEIGHT = 1024,
  parameter  int INPUT_NB_CHANNELS  = 64,
  parameter  int OUTPUT_NB_CHANNELS = 64,
  parameter  int KERNEL_SIZE        = 3,
  parameter  int CH_PER_MAC         = 4,
  parameter  int MAC_LATENCY        = 2,
  parameter  int ODS_BEATS          = 2,
  localparam int XW = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1,
  localparam int YW = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
  localparam int OW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1
) (
  input  logic          clk,
  input  logic          arst_n_in,
  input  logic          start,
  input  logic          abort,
  input  logic [2:0]    con_valid,
`ifdef CONV_LOOP_CTRL_OUT_HANDSHAKE_EN
  input  logic          output_ready,
`endif
  output logic [2:0]    con_ready,
  output logic          kds_le,
  output logic          idss_le,
  output logic          idss_shift,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          ods_sel_out,
  output logic          ods_shift,
  output logic          driving_cons,
  output logic          output_valid,
  output logic [XW-1:0] output_x,
  output logic [YW-1:0] output_y,
  output logic [OW-1:0] output_ch,
  output logic          running,
  output logic          done
);

  localparam int KB   = KERNEL_SIZE * CH_PER_MAC;
  localparam int NG   = INPUT_NB_CHANNELS / CH_PER_MAC;
  localparam int GW   = (NG > 1) ? $clog2(NG) : 1;
  localparam int CM0  = (KB > MAC_LATENCY) ? KB : MAC_LATENCY;
  localparam int CMAX = (CM0 > ODS_BEATS) ? CM0 : ODS_BEATS;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] KB_LAST  = CW'(KB - 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(MAC_LATENCY - 1);
  localparam logic [CW-1:0] OB_LAST  = CW'(ODS_BEATS - 1);
  localparam logic [GW-1:0] G_LAST   = GW'(NG - 1);
  localparam logic [OW-1:0] OC_LAST  = OW'(OUTPUT_NB_CHANNELS - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(FEATURE_MAP_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(FEATURE_MAP_HEIGHT - 1);

  typedef enum logic [2:0] {IDLE, LOAD_K, LOAD_I, MAC, OUTPUT} state_t;

  state_t        r_st, w_nxt;
  logic [CW-1:0] r_cnt;
  logic [GW-1:0] r_cg;
  logic [OW-1:0] r_oc;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_first, r_done;
  logic          w_beat, w_ordy, w_oshift, w_cnt_inc, w_last_res, w_done_set;

`ifdef CONV_LOOP_CTRL_OUT_HANDSHAKE_EN
  logic r_acked;
  assign w_ordy       = output_ready;
  assign output_valid = (r_st == OUTPUT) && !r_acked;
`else
  assign w_ordy       = 1'b1;
  assign output_valid = r_first;
`endif

  // A beat needs every con valid at once; ready itself is decoded from state only.
  assign w_beat     = ((r_st == LOAD_K) || (r_st == LOAD_I)) && (&con_valid);
  assign w_oshift   = (r_st == OUTPUT) && w_ordy;
  assign w_last_res = (r_oc == OC_LAST) && (r_x == X_LAST) && (r_y == Y_LAST);

  always_comb begin
    w_nxt        = r_st;
    w_done_set   = 1'b0;
    w_cnt_inc    = 1'b0;
    con_ready    = 3'b000;
    kds_le       = 1'b0;
    idss_le      = 1'b0;
    idss_shift   = 1'b0;
    mac_en       = 1'b0;
    mac_clr      = 1'b0;
    ods_sel_out  = 1'b0;
    ods_shift    = 1'b0;
    driving_cons = 1'b0;
    case (r_st)
      IDLE: if (start) w_nxt = LOAD_K;
      LOAD_K: begin
        con_ready = 3'b111;
        kds_le    = w_beat;
        w_cnt_inc = w_beat;
        if (w_beat && (r_cnt == KB_LAST)) w_nxt = LOAD_I;
      end
      LOAD_I: begin
        con_ready  = 3'b111;
        idss_le    = w_beat;
        idss_shift = w_beat;
        w_cnt_inc  = w_beat;
        if (w_beat && (r_cnt == KB_LAST)) w_nxt = MAC;
      end
      MAC: begin
        mac_en    = (r_cnt == '0);
        mac_clr   = (r_cnt == '0) && (r_cg == '0);
        w_cnt_inc = 1'b1;
        if (r_cnt == LAT_LAST) w_nxt = (r_cg == G_LAST) ? OUTPUT : LOAD_K;
      end
      OUTPUT: begin
        driving_cons = 1'b1;
        ods_sel_out  = r_first;
        ods_shift    = w_oshift;
        w_cnt_inc    = w_oshift;
        if (w_oshift && (r_cnt == OB_LAST)) begin
          if (w_last_res) begin
            w_nxt      = IDLE;
            w_done_set = 1'b1;
          end else begin
            w_nxt = LOAD_K;
          end
        end
      end
      default: w_nxt = IDLE;
    endcase
    if (abort) begin
      w_nxt      = IDLE;
      w_done_set = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      r_st    <= IDLE;
      r_cnt   <= '0;
      r_cg    <= '0;
      r_oc    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_first <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_st    <= w_nxt;
      r_done  <= w_done_set;
      r_first <= (w_nxt == OUTPUT) && (r_st != OUTPUT);
      if (w_nxt != r_st)  r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
      // Loop nest, innermost first: cg, output_ch, output_x, output_y.
      if (abort || ((r_st == IDLE) && start)) begin
        r_cg <= '0;
        r_oc <= '0;
        r_x  <= '0;
        r_y  <= '0;
      end else if ((r_st == MAC) && (w_nxt == LOAD_K)) begin
        r_cg <= r_cg + 1'b1;
      end else if ((r_st == OUTPUT) && (w_nxt != OUTPUT)) begin
        r_cg <= '0;
        if (r_oc == OC_LAST) begin
          r_oc <= '0;
          if (r_x == X_LAST) begin
            r_x <= '0;
            r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
          end else begin
            r_x <= r_x + 1'b1;
          end
        end else begin
          r_oc <= r_oc + 1'b1;
        end
      end
    end
  end

`ifdef CONV_LOOP_CTRL_OUT_HANDSHAKE_EN
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) r_acked <= 1'b0;
    else            r_acked <= (w_nxt == OUTPUT) && (r_st == OUTPUT) && (r_acked || output_ready);
  end
`endif

  assign running   = (r_st != IDLE);
  assign done      = r_done;
  assign output_x  = r_x;
  assign output_y  = r_y;
  assign output_ch = r_oc;

endmodule

// File: tb/tb_conv_loop_ctrl.sv
// Bench for conv_loop_ctrl: W=H=2, IC=8 (two MAC passes per result), OC=2, 12-beat loads, 2-beat output.
module tb_conv_loop_ctrl;
  localparam int W = 2, H = 2, IC = 8, OC = 2, KS = 3, CPM = 4, LAT = 2, OB = 2;
  localparam int KB = KS * CPM, NG = IC / CPM, NRES = W * H * OC;
`ifdef CONV_LOOP_CTRL_OUT_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       arst_n_in, start, abort, o_rdy;
  logic [2:0] con_valid, con_ready;
  logic       kds_le, idss_le, idss_shift, mac_en, mac_clr, ods_sel_out, ods_shift;
  logic       driving_cons, output_valid, running, done;
  logic [0:0] output_x, output_y, output_ch;

  conv_loop_ctrl #(
    .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .INPUT_NB_CHANNELS(IC),
    .OUTPUT_NB_CHANNELS(OC), .KERNEL_SIZE(KS), .CH_PER_MAC(CPM),
    .MAC_LATENCY(LAT), .ODS_BEATS(OB)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .abort(abort), .con_valid(con_valid),
`ifdef CONV_LOOP_CTRL_OUT_HANDSHAKE_EN
    .output_ready(o_rdy),
`endif
    .con_ready(con_ready), .kds_le(kds_le), .idss_le(idss_le), .idss_shift(idss_shift),
    .mac_en(mac_en), .mac_clr(mac_clr), .ods_sel_out(ods_sel_out), .ods_shift(ods_shift),
    .driving_cons(driving_cons), .output_valid(output_valid), .output_x(output_x),
    .output_y(output_y), .output_ch(output_ch), .running(running), .done(done)
  );

  initial forever #5 clk = ~clk;

  int checks, fails, cyc, t0;
  int kbeats, ibeats, pass, res_idx, shifts, hx, hy, hc;
  int k_total, i_total, mac_total, clr_total, ov_total, done_total;
  int first_ov, done_cyc, first_idss, first_tag;
  bit dc_prev, rdy_seen;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mdl_reset();
    kbeats = 0; ibeats = 0; pass = 0; res_idx = 0; shifts = 0;
    k_total = 0; i_total = 0; mac_total = 0; clr_total = 0; ov_total = 0; done_total = 0;
    first_ov = -1; done_cyc = -1; first_idss = -1; first_tag = -1;
    dc_prev = 1'b0; rdy_seen = 1'b0; hx = 0; hy = 0; hc = 0;
  endtask

  // Result-level model: expected tag comes from the result index, beats/passes are tallied per phase.
  task automatic monitor();
    bit beat, exp_ov;
    cyc++;
    beat = (con_ready == 3'b111) && (con_valid == 3'b111);
    chk("ready_level", int'(con_ready == 3'b000 || con_ready == 3'b111), 1);
    chk("beat_strobe", kds_le | idss_le, beat);
    chk("kds_idss_excl", kds_le & idss_le, 0);
    chk("idss_shift", idss_shift, idss_le);
    chk("clr_only_w_en", mac_clr & ~mac_en, 0);
    if (driving_cons) chk("ready_while_out", con_ready, 0);
    if (!running)
      chk("idle_quiet", {con_ready, kds_le, idss_le, mac_en, driving_cons, output_valid, ods_shift}, 0);
    if (kds_le) begin
      chk("k_before_i", ibeats, 0);
      kbeats++; k_total++;
    end
    if (idss_le) begin
      chk("k_loaded", kbeats, KB);
      ibeats++; i_total++;
      if (first_idss < 0) first_idss = cyc;
    end
    if (mac_en) begin
      chk("mac_k_beats", kbeats, KB);
      chk("mac_i_beats", ibeats, KB);
      chk("mac_clr", mac_clr, int'(pass == 0));
      kbeats = 0; ibeats = 0; pass++; mac_total++;
      if (mac_clr) clr_total++;
    end
    if (driving_cons && !dc_prev) begin
      chk("passes_per_result", pass, NG);
      chk("sel_out_first", ods_sel_out, 1);
      chk("tag_ch", output_ch, res_idx % OC);
      chk("tag_x", output_x, (res_idx / OC) % W);
      chk("tag_y", output_y, res_idx / (OC * W));
      hx = output_x; hy = output_y; hc = output_ch;
      pass = 0; shifts = 0; rdy_seen = 1'b0;
      if (first_ov < 0) first_ov = cyc;
      if (first_tag < 0) first_tag = (int'(output_y) << 2) | (int'(output_x) << 1) | int'(output_ch);
    end else begin
      chk("sel_out_other", ods_sel_out, 0);
    end
    if (driving_cons && dc_prev) chk("tag_stable", {output_y, output_x, output_ch}, {hy[0], hx[0], hc[0]});
    exp_ov = driving_cons && (HS ? !rdy_seen : !dc_prev);
    chk("output_valid", output_valid, exp_ov);
    if (output_valid) ov_total++;
    chk("ods_shift", ods_shift, driving_cons && o_rdy);
    if (ods_shift) shifts++;
    if (driving_cons && o_rdy) rdy_seen = 1'b1;
    if (!driving_cons && dc_prev) begin
      chk("shifts_per_result", shifts, OB);
      res_idx++;
    end
    dc_prev = driving_cons;
    if (done) begin
      chk("done_all_results", res_idx, NRES);
      chk("done_not_running", running, 0);
      done_total++;
      if (done_cyc < 0) done_cyc = cyc;
    end
  endtask

  task automatic smp(); @(negedge clk); monitor(); endtask
  task automatic adv(); @(posedge clk); #1; endtask
  task automatic step(); smp(); adv(); endtask

  task automatic launch();
    start = 1'b1; step(); start = 1'b0;
    t0 = cyc + 1;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done_cyc < 0 && n < bound) begin step(); n++; end
    chk("done_seen", int'(done_cyc >= 0), 1);
  endtask

  initial begin
    checks = 0; fails = 0; cyc = 0; t0 = 0;
    arst_n_in = 1'b0; start = 1'b0; abort = 1'b0; con_valid = 3'b111; o_rdy = 1'b1;
    mdl_reset();
    #3;
    chk("rst_running", running, 0);
    chk("rst_ready", con_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_outputs", {output_valid, driving_cons, mac_en, kds_le, output_x, output_y, output_ch}, 0);
    #4 arst_n_in = 1'b1;
    adv();

    // Clean layer: 54 cycles per result, first result at cycle 53, done at cycle 433.
    mdl_reset(); launch(); wait_done(1000);
    chk("A_first_ov_lat", first_ov - t0, 52);
    chk("A_done_lat", done_cyc - t0, 432);
    chk("A_k_beats", k_total, 192);
    chk("A_i_beats", i_total, 192);
    chk("A_mac_passes", mac_total, 16);
    chk("A_mac_clrs", clr_total, 8);
    chk("A_results", ov_total, 8);
    repeat (3) step();
    chk("A_done_once", done_total, 1);

    // Partial valid stalls LOAD_K; LOAD_I then begins 5 cycles late (cycle 18).
    mdl_reset(); launch();
    repeat (3) step();
    con_valid = 3'b101;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("B_no_kds", kds_le, 0);
      chk("B_held_load_k", con_ready, 3'b111);
      adv();
    end
    con_valid = 3'b111;
    for (int n = 0; n < 50 && first_idss < 0; n++) step();
    chk("B_first_idss_lat", first_idss - t0, 17);
    abort = 1'b1; step(); abort = 1'b0;
    mdl_reset(); smp();
    chk("B_abort_running", running, 0);
    chk("B_abort_ready", con_ready, 0);
    chk("B_abort_done", done, 0);
    adv();

    // Abort together with start on the final output beat (cycle 432).
    mdl_reset(); launch();
    while (cyc < t0 + 430) step();
    abort = 1'b1; start = 1'b1;
    smp();
    chk("C_final_beat_dc", driving_cons, 1);
    chk("C_final_beat_shift", ods_shift, 1);
    chk("C_results_before", ov_total, 8);
    adv();
    abort = 1'b0; start = 1'b0;
    mdl_reset(); smp();
    chk("C_running", running, 0);
    chk("C_done", done, 0);
    chk("C_dc", driving_cons, 0);
    adv(); smp();
    chk("C_still_idle", running, 0);
    chk("C_no_done", done, 0);
    adv();

    // Asynchronous reset during LOAD_I beat 7 (cycle 19), then restart on first edge after release.
    mdl_reset(); launch();
    while (cyc < t0 + 17) step();
    #2;
    chk("D_in_load_i", idss_le, 1);
    arst_n_in = 1'b0;
    #1;
    chk("D_async_running", running, 0);
    chk("D_async_ready", con_ready, 0);
    chk("D_async_strobes", {kds_le, idss_le, idss_shift, mac_en, mac_clr, ods_sel_out, ods_shift,
                            driving_cons, output_valid, done}, 0);
    chk("D_async_tags", {output_x, output_y, output_ch}, 0);
    mdl_reset(); smp();
    start = 1'b1;
    #2 arst_n_in = 1'b1;
    adv();
    start = 1'b0; t0 = cyc + 1;
    smp();
    chk("D_restart_running", running, 1);
    chk("D_restart_ready", con_ready, 3'b111);
    adv();
    wait_done(1000);
    chk("D_first_tag", first_tag, 0);
    chk("D_done_lat", done_cyc - t0, 432);

`ifdef CONV_LOOP_CTRL_OUT_HANDSHAKE_EN
    // output_ready low: valid and tags held, no shifts; 11 stall cycles push done to 443.
    mdl_reset(); o_rdy = 1'b0; launch();
    for (int n = 0; n < 100 && first_ov < 0; n++) step();
    for (int i = 0; i < 10; i++) begin
      smp();
      chk("E_valid_held", output_valid, 1);
      chk("E_no_shift", ods_shift, 0);
      chk("E_tags", {output_x, output_y, output_ch}, 0);
      adv();
    end
    o_rdy = 1'b1;
    wait_done(1000);
    chk("E_first_ov_lat", first_ov - t0, 52);
    chk("E_done_lat", done_cyc - t0, 443);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
